// File: rtl/dmem_arbiter.sv
// Arbitrates data_memory between the core load/store port (fixed priority) and a DMA port,
// with a starvation counter that forces one DMA beat. Optional perf counters: DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_mem_read,
  input  logic                  core_mem_write,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [1:0]            core_ls_type,
  input  logic                  core_unsigned,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  dma_valid,
  input  logic                  dma_write,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  input  logic [1:0]            dma_ls_type,
  input  logic                  dma_unsigned,
  output logic                  dma_ready,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            load_store_type,
  output logic                  load_unsigned,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [31:0]           perf_core_stalls,
  output logic [31:0]           perf_dma_beats
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {PRI_CORE, FORCE_DMA} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   starve_cnt;
  logic            core_req, grant_dma, stall_raw, refused, handshake, at_limit;

  assign core_req   = core_mem_read | core_mem_write;
  assign at_limit   = (starve_cnt == CW'(STARVE_LIMIT - 1));
  assign core_rdata = mem_read_data;
  assign handshake  = dma_valid & dma_ready;

  always_comb begin
    grant_dma       = 1'b0;
    stall_raw       = 1'b0;
    state_nxt       = PRI_CORE;
    mem_addr        = core_addr;
    mem_write_data  = core_wdata;
    load_store_type = core_ls_type;
    load_unsigned   = core_unsigned;
    mem_read        = core_mem_read;
    mem_write       = core_mem_write;
    case (state)
      PRI_CORE:  grant_dma = dma_valid & ~core_req;
      FORCE_DMA: begin
        grant_dma = dma_valid;
        stall_raw = core_req & dma_valid;
      end
      default:   grant_dma = 1'b0;
    endcase
    refused = dma_valid & ~grant_dma;
    if (refused && at_limit) state_nxt = FORCE_DMA;
    if (grant_dma) begin
      mem_addr        = dma_addr;
      mem_write_data  = dma_wdata;
      load_store_type = dma_ls_type;
      load_unsigned   = dma_unsigned;
      mem_read        = ~dma_write;
      mem_write       = dma_write;
    end
    // Strobes and handshakes are held off for the whole reset pulse, not just at the edge.
    dma_ready  = grant_dma & ~rst;
    core_stall = stall_raw & ~rst;
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRI_CORE;
      starve_cnt <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      dma_rvalid <= handshake & ~dma_write;
      if (handshake && !dma_write) dma_rdata <= mem_read_data;
      if (!dma_valid || handshake || (refused && at_limit)) starve_cnt <= '0;
      else if (refused)                                      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_core_stalls <= '0;
      perf_dma_beats   <= '0;
    end else begin
      if (core_stall && perf_core_stalls != 32'hFFFF_FFFF) perf_core_stalls <= perf_core_stalls + 32'd1;
      if (handshake && perf_dma_beats != 32'hFFFF_FFFF)    perf_dma_beats   <= perf_dma_beats + 32'd1;
    end
  end
`else
  assign perf_core_stalls = '0;
  assign perf_dma_beats   = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory instance between the core load/store port and a DMA/loader port (program load, debug peek/poke).
- Core has fixed priority. A starvation counter forces one DMA beat after STARVE_LIMIT consecutive refused cycles, stalling the core for that cycle.
- Sits between the core datapath/control and data_memory. Drives data_memory's mem_addr, mem_write_data, mem_read, mem_write, load_store_type and load_unsigned.

Parameters:
- ADDR_WIDTH, 32, address width of both requester ports and the memory port.
- DATA_WIDTH, 32, data width.
- STARVE_LIMIT, 4, consecutive refused DMA cycles before a forced grant (legal range ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- core_mem_read  in  1  core load request.
- core_mem_write  in  1  core store request.
- core_addr  in  ADDR_WIDTH  core byte address.
- core_wdata  in  DATA_WIDTH  core store data.
- core_ls_type  in  2  `LS_BYTE/`LS_HALF/`LS_WORD.
- core_unsigned  in  1  core zero-extend load.
- core_rdata  out  DATA_WIDTH  load data; equals mem_read_data, combinational.
- core_stall  out  1  core access refused this cycle.
- dma_valid  in  1  DMA request valid.
- dma_write  in  1  1 = store, 0 = load.
- dma_addr  in  ADDR_WIDTH  DMA byte address.
- dma_wdata  in  DATA_WIDTH  DMA store data.
- dma_ls_type  in  2  DMA access size.
- dma_unsigned  in  1  DMA zero-extend load.
- dma_ready  out  1  DMA beat accepted this cycle.
- dma_rvalid  out  1  dma_rdata valid; one-cycle pulse.
- dma_rdata  out  DATA_WIDTH  registered DMA load data.
- mem_addr  out  ADDR_WIDTH  to data_memory.
- mem_write_data  out  DATA_WIDTH  to data_memory.
- mem_read  out  1  to data_memory.
- mem_write  out  1  to data_memory.
- load_store_type  out  2  to data_memory.
- load_unsigned  out  1  to data_memory.
- mem_read_data  in  DATA_WIDTH  from data_memory (combinational read).

Behaviour:
- Definitions: core_req = core_mem_read | core_mem_write. Handshake = dma_valid & dma_ready.
- FSM states: PRI_CORE (reset state) and FORCE_DMA.
- PRI_CORE:
  - dma_ready = dma_valid & ~core_req; core_stall = 0.
  - Memory mux selects the DMA fields when dma_ready, otherwise the core fields.
- FORCE_DMA:
  - dma_ready = dma_valid; core_stall = core_req & dma_valid.
  - Mux selects DMA when dma_valid, otherwise core (no stall if DMA dropped valid).
- Memory strobes are gated by the granted side:
  - DMA granted: mem_read = ~dma_write, mem_write = dma_write.
  - Core granted: mem_read = core_mem_read, mem_write = core_mem_write.
  - No request: all mem_* strobes 0. Address and data follow the core fields.
- Starvation counter starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments on each cycle with dma_valid & ~dma_ready.
  - Cleared on a handshake or whenever dma_valid = 0.
  - On a refused cycle where starve_cnt == STARVE_LIMIT-1: next state FORCE_DMA, counter cleared.
- FORCE_DMA → PRI_CORE after exactly one cycle: handshake taken, or valid dropped.
- Latency:
  - Core access completes in the same cycle; stores are written at the clk edge.
  - DMA store is written at the handshake edge.
  - DMA load: mem_read_data is captured at the handshake edge into dma_rdata, and dma_rvalid is high the following cycle only.
  - Back-to-back DMA loads give consecutive dma_rvalid pulses.
- Simultaneous core_mem_read & core_mem_write is illegal. The arbiter passes both strobes through unchanged and does not check.
- Reset (async assert, sync release):
  - State PRI_CORE, starve_cnt 0, dma_rvalid 0, dma_rdata 0.
  - While rst = 1, mem_write, mem_read, dma_ready and core_stall are forced to 0.
  - Reset mid-FORCE_DMA returns to PRI_CORE. Any pending dma_rvalid is dropped.
- Addresses are passed unmodified; alignment handling belongs to data_memory.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined, adds outputs perf_core_stalls [31:0] and perf_dma_beats [31:0]:
  - perf_core_stalls counts cycles with core_stall = 1.
  - perf_dma_beats counts handshakes.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- When undefined, the ports exist but are tied to 0 and no counter logic is built.

Test Plan:
- Idle DMA; core stores 32'hF0F0F0F0 (`LS_WORD) at 0x1C, then loads 0x1C → mem_write for 1 cycle, core_rdata = 32'hF0F0F0F0, core_stall = 0 throughout.
- Core idle; DMA store `LS_BYTE 0xA5 at 0x16, then DMA load `LS_BYTE unsigned at 0x16 → dma_ready same cycle as each request; dma_rvalid = 1 one cycle after the load with dma_rdata = 32'h000000A5.
- STARVE_LIMIT = 4; core requests every cycle; dma_valid held from cycle 0 → dma_ready low cycles 0–3; cycle 4 dma_ready = 1 and core_stall = 1; cycle 5 core granted again; cycles 5–8 refused, forced grant at cycle 9.
- Signed DMA `LS_HALF load of 16'h8001 → dma_rdata = 32'hFFFF8001; same load with dma_unsigned = 1 → 32'h00008001.
- Assert rst during FORCE_DMA with a pending DMA load → mem_* strobes 0 immediately; after release state is PRI_CORE, dma_rvalid = 0, first refused DMA cycle gives starve_cnt = 1.
- With DMEM_ARB_PERF_EN, run the starvation scenario for 10 cycles → perf_core_stalls = 2, perf_dma_beats = 2; without the macro both read 0.
